// File: rtl/hls_macc_driver.sv
// hls_macc_driver: host request/response driver for an HLS ap_ctrl_hs accelerator with ap_vld outputs
//   ap_clk, ap_rst_n              clock, async active-low reset
//   req_valid/req_ready/req_data  host request, ten 32-bit operands packed in1 at [31:0]
//   rsp_valid/rsp_ready           host response handshake
//   rsp_out1..3, rsp_vld_mask     captured results and which ap_vld strobes were seen
//   rsp_timeout                   transaction aborted after TIMEOUT start cycles
//   acc_*                         accelerator ap_start/done/idle/ready, operands, results, strobes
//   txn_count                     completed transactions, timeouts included
module hls_macc_driver #(
  parameter int TIMEOUT = 255
) (
  input  logic         ap_clk,
  input  logic         ap_rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [319:0] req_data,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [31:0]  rsp_out1,
  output logic [31:0]  rsp_out2,
  output logic [31:0]  rsp_out3,
  output logic [2:0]   rsp_vld_mask,
  output logic         rsp_timeout,
  output logic         acc_start,
  input  logic         acc_done,
  input  logic         acc_idle,
  input  logic         acc_ready,
  output logic [319:0] acc_in,
  input  logic [31:0]  acc_out1,
  input  logic [31:0]  acc_out2,
  input  logic [31:0]  acc_out3,
  input  logic         acc_out1_vld,
  input  logic         acc_out2_vld,
  input  logic         acc_out3_vld,
  output logic [15:0]  txn_count
);
  typedef enum logic [1:0] {IDLE, START, RESP} state_t;
  localparam logic [7:0] TO = 8'(TIMEOUT);
  state_t state;
  logic [319:0] op;
  logic [7:0] tcnt;
  logic [7:0] tcnt_nxt;
  logic [15:0] txn_cnt;
  assign tcnt_nxt = tcnt + 8'd1;
  assign req_ready = (state == IDLE) && acc_idle;
  assign rsp_valid = state == RESP;
  assign acc_in = op;
  assign txn_count = txn_cnt;
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) begin
      state <= IDLE;
      op <= '0;
      tcnt <= '0;
      txn_cnt <= '0;
      acc_start <= 1'b0;
      rsp_out1 <= '0;
      rsp_out2 <= '0;
      rsp_out3 <= '0;
      rsp_vld_mask <= '0;
      rsp_timeout <= 1'b0;
    end else
      case (state)
        IDLE:
          if (req_valid && acc_idle) begin
            op <= req_data;
            tcnt <= '0;
            rsp_out1 <= '0;
            rsp_out2 <= '0;
            rsp_out3 <= '0;
            rsp_vld_mask <= '0;
            rsp_timeout <= 1'b0;
            acc_start <= 1'b1;
            state <= START;
          end
        START: begin
          if (acc_out1_vld) begin
            rsp_out1 <= acc_out1;
            rsp_vld_mask[0] <= 1'b1;
          end
          if (acc_out2_vld) begin
            rsp_out2 <= acc_out2;
            rsp_vld_mask[1] <= 1'b1;
          end
          if (acc_out3_vld) begin
            rsp_out3 <= acc_out3;
            rsp_vld_mask[2] <= 1'b1;
          end
          if (acc_ready) acc_start <= 1'b0;
          if (acc_done) begin
            acc_start <= 1'b0;
            state <= RESP;
          end else begin
            tcnt <= tcnt_nxt;
            // abort on the START cycle whose increment reaches TIMEOUT, so acc_start is high for at most TIMEOUT cycles
            if (tcnt_nxt == TO) begin
              rsp_timeout <= 1'b1;
              acc_start <= 1'b0;
              state <= RESP;
            end
          end
        end
        RESP:
          if (rsp_ready) begin
            txn_cnt <= txn_cnt + 16'd1;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_hls_macc_driver.sv
// tb_hls_macc_driver: randomized self-checking bench for hls_macc_driver against a transaction-level model
module tb_hls_macc_driver;
  localparam int TO = 4;
  logic ap_clk, ap_rst_n;
  logic req_valid, req_ready, rsp_valid, rsp_ready;
  logic [319:0] req_data, acc_in;
  logic [31:0] rsp_out1, rsp_out2, rsp_out3;
  logic [2:0] rsp_vld_mask;
  logic rsp_timeout, acc_start, acc_done, acc_idle, acc_ready;
  logic [31:0] acc_out1, acc_out2, acc_out3;
  logic acc_out1_vld, acc_out2_vld, acc_out3_vld;
  logic [15:0] txn_count;
  int checks = 0;
  int errors = 0;
  bit e_idle = 1;
  bit e_start = 0;
  bit e_valid = 0;
  bit e_to = 0;
  logic [2:0] e_mask = 0;
  logic [31:0] e_out [3] = '{0, 0, 0};
  logic [15:0] e_cnt = 0;
  logic [319:0] e_op = 0;

  hls_macc_driver #(.TIMEOUT(TO)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_out1(rsp_out1), .rsp_out2(rsp_out2), .rsp_out3(rsp_out3),
    .rsp_vld_mask(rsp_vld_mask), .rsp_timeout(rsp_timeout),
    .acc_start(acc_start), .acc_done(acc_done), .acc_idle(acc_idle), .acc_ready(acc_ready),
    .acc_in(acc_in), .acc_out1(acc_out1), .acc_out2(acc_out2), .acc_out3(acc_out3),
    .acc_out1_vld(acc_out1_vld), .acc_out2_vld(acc_out2_vld), .acc_out3_vld(acc_out3_vld),
    .txn_count(txn_count)
  );

  initial ap_clk = 0;
  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge ap_clk) begin
    chk("req_ready", 320'(req_ready), 320'(e_idle & acc_idle));
    chk("acc_start", 320'(acc_start), 320'(e_start));
    chk("rsp_valid", 320'(rsp_valid), 320'(e_valid));
    chk("rsp_out1", 320'(rsp_out1), 320'(e_out[0]));
    chk("rsp_out2", 320'(rsp_out2), 320'(e_out[1]));
    chk("rsp_out3", 320'(rsp_out3), 320'(e_out[2]));
    chk("rsp_vld_mask", 320'(rsp_vld_mask), 320'(e_mask));
    chk("rsp_timeout", 320'(rsp_timeout), 320'(e_to));
    chk("txn_count", 320'(txn_count), 320'(e_cnt));
    chk("acc_in", acc_in, e_op);
  end

  function automatic logic [319:0] rnd320();
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic noise();
    acc_idle = 1'($urandom);
    acc_done = 1'($urandom);
    acc_ready = 1'($urandom);
    {acc_out3_vld, acc_out2_vld, acc_out1_vld} = 3'($urandom);
    acc_out1 = $urandom;
    acc_out2 = $urandom;
    acc_out3 = $urandom;
  endtask

  task automatic idle_noise(input int n);
    for (int i = 0; i < n; i++) begin
      noise();
      req_valid = !acc_idle && 1'($urandom);
      rsp_ready = 1'($urandom);
      tick();
    end
  endtask

  // accept a request and run the accelerator side until the driver should be presenting its response
  task automatic start_txn(input logic [319:0] d, input int done_at, input int ready_at, input bit rnd,
                           input logic [2:0] vm, input logic [31:0] v1, input logic [31:0] v2,
                           input logic [31:0] v3, input bit keep);
    bit to;
    int n;
    to = done_at < 1 || done_at > TO;
    n = to ? TO : done_at;
    req_valid = 1;
    req_data = d;
    acc_idle = 1;
    acc_done = 0;
    acc_ready = 0;
    {acc_out3_vld, acc_out2_vld, acc_out1_vld} = 0;
    tick();
    e_idle = 0;
    e_op = d;
    e_out = '{0, 0, 0};
    e_mask = 0;
    e_to = 0;
    e_start = 1;
    req_valid = keep;
    req_data = rnd320();
    for (int i = 1; i <= n; i++) begin
      acc_idle = 1'($urandom);
      rsp_ready = 1'($urandom);
      acc_done = i == done_at;
      acc_ready = i == ready_at;
      if (rnd) begin
        {acc_out3_vld, acc_out2_vld, acc_out1_vld} = 3'($urandom);
        acc_out1 = $urandom;
        acc_out2 = $urandom;
        acc_out3 = $urandom;
      end else begin
        {acc_out3_vld, acc_out2_vld, acc_out1_vld} = (i == done_at) ? vm : 3'b000;
        acc_out1 = v1;
        acc_out2 = v2;
        acc_out3 = v3;
      end
      tick();
      if (acc_out1_vld) begin e_out[0] = acc_out1; e_mask[0] = 1; end
      if (acc_out2_vld) begin e_out[1] = acc_out2; e_mask[1] = 1; end
      if (acc_out3_vld) begin e_out[2] = acc_out3; e_mask[2] = 1; end
      e_start = !(ready_at >= 1 && ready_at <= i);
    end
    e_start = 0;
    e_to = to;
    e_valid = 1;
    rsp_ready = 0;
    noise();
  endtask

  task automatic finish_txn(input int stall);
    rsp_ready = 0;
    for (int i = 0; i < stall; i++) begin
      noise();
      tick();
    end
    rsp_ready = 1;
    noise();
    tick();
    rsp_ready = 0;
    req_valid = 0;
    e_valid = 0;
    e_idle = 1;
    e_cnt++;
    acc_done = 0;
    acc_ready = 0;
    {acc_out3_vld, acc_out2_vld, acc_out1_vld} = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [319:0] d;
    ap_rst_n = 0;
    req_valid = 0;
    req_data = 0;
    rsp_ready = 0;
    acc_done = 0;
    acc_idle = 1;
    acc_ready = 0;
    acc_out1 = 0;
    acc_out2 = 0;
    acc_out3 = 0;
    {acc_out3_vld, acc_out2_vld, acc_out1_vld} = 0;
    repeat (3) tick();
    acc_idle = 0;
    tick();
    ap_rst_n = 1;
    idle_noise(2);

    d = 0;
    d[31:0] = 2;
    d[63:32] = 3;
    d[95:64] = 4;
    start_txn(d, 3, 3, 0, 3'b111, 22, 5, 7, 0);
    chk("basic_out1", 320'(rsp_out1), 320'(22));
    chk("basic_out2", 320'(rsp_out2), 320'(5));
    chk("basic_out3", 320'(rsp_out3), 320'(7));
    chk("basic_mask", 320'(rsp_vld_mask), 320'(3'b111));
    chk("basic_timeout", 320'(rsp_timeout), 320'(0));
    finish_txn(2);
    chk("basic_count", 320'(txn_count), 320'(1));

    start_txn(rnd320(), 2, 1, 0, 3'b010, 32'hdead, 32'h1234, 32'hbeef, 0);
    chk("partial_out1", 320'(rsp_out1), 320'(0));
    chk("partial_out2", 320'(rsp_out2), 320'(32'h1234));
    chk("partial_out3", 320'(rsp_out3), 320'(0));
    chk("partial_mask", 320'(rsp_vld_mask), 320'(3'b010));
    finish_txn(0);

    start_txn(rnd320(), 0, 0, 0, 3'b000, 0, 0, 0, 0);
    chk("timeout_flag", 320'(rsp_timeout), 320'(1));
    chk("timeout_mask", 320'(rsp_vld_mask), 320'(0));
    chk("timeout_start", 320'(acc_start), 320'(0));
    finish_txn(1);
    for (int i = 0; i < 3; i++) begin
      acc_idle = 0;
      acc_done = 1;
      acc_ready = 1;
      {acc_out3_vld, acc_out2_vld, acc_out1_vld} = 3'b111;
      acc_out1 = $urandom;
      tick();
    end
    chk("late_done_timeout", 320'(rsp_timeout), 320'(1));
    chk("late_done_valid", 320'(rsp_valid), 320'(0));

    start_txn(rnd320(), TO, 2, 1, 0, 0, 0, 0, 0);
    chk("done_at_limit", 320'(rsp_timeout), 320'(0));
    finish_txn(0);
    start_txn(rnd320(), TO + 1, TO + 1, 1, 0, 0, 0, 0, 0);
    chk("done_past_limit", 320'(rsp_timeout), 320'(1));
    finish_txn(0);

    start_txn(rnd320(), 2, 2, 1, 0, 0, 0, 0, 1);
    finish_txn(10);
    idle_noise(1);

    for (int t = 0; t < 40; t++) begin
      start_txn(rnd320(), $urandom_range(0, TO + 2), $urandom_range(0, TO + 2), 1, 0, 0, 0, 0,
                1'($urandom));
      finish_txn($urandom_range(0, 3));
      idle_noise($urandom_range(0, 2));
    end

    req_valid = 1;
    req_data = rnd320();
    acc_idle = 1;
    acc_done = 0;
    acc_ready = 0;
    {acc_out3_vld, acc_out2_vld, acc_out1_vld} = 0;
    tick();
    e_idle = 0;
    e_op = req_data;
    e_out = '{0, 0, 0};
    e_mask = 0;
    e_to = 0;
    e_start = 1;
    req_valid = 0;
    acc_idle = 0;
    tick();
    #1 ap_rst_n = 0;
    #1;
    chk("rst_acc_start", 320'(acc_start), 320'(0));
    chk("rst_rsp_valid", 320'(rsp_valid), 320'(0));
    chk("rst_txn_count", 320'(txn_count), 320'(0));
    chk("rst_acc_in", acc_in, 320'(0));
    e_idle = 1;
    e_start = 0;
    e_valid = 0;
    e_to = 0;
    e_mask = 0;
    e_out = '{0, 0, 0};
    e_cnt = 0;
    e_op = 0;
    idle_noise(2);
    ap_rst_n = 1;
    acc_idle = 1;
    tick();
    start_txn(rnd320(), 1, 1, 1, 0, 0, 0, 0, 0);
    finish_txn(1);
    chk("post_reset_count", 320'(txn_count), 320'(1));

    force dut.txn_cnt = 16'hffff;
    #1;
    release dut.txn_cnt;
    e_cnt = 16'hffff;
    tick();
    start_txn(rnd320(), 2, 1, 1, 0, 0, 0, 0, 0);
    finish_txn(0);
    chk("wrap_count", 320'(txn_count), 320'(0));
    idle_noise(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
